// File: rtl/switch_pkg.sv
// switch_pkg: shared sizes, types and index helper for the switch ingress arbiter.
package switch_pkg;
    localparam int NUM_PORTS  = 4;
    localparam int DATA_W     = 32;
    localparam int FIFO_DEPTH = 4;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [$clog2(NUM_PORTS)-1:0] port_idx_t;

    function automatic port_idx_t port_add(port_idx_t a, int o);
        return port_idx_t'((int'(a) + o) % NUM_PORTS);
    endfunction
endpackage

// File: rtl/switch_port_fifo.sv
// switch_port_fifo: per-port word FIFO with registered count-derived full/empty flags.
module switch_port_fifo
    import switch_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  push_i,
    input  logic  pop_i,
    input  word_t data_i,
    output logic  full_o,
    output logic  empty_o,
    output word_t head_o
);
    localparam int AW = $clog2(DEPTH);

    word_t         mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, wr_ptr_q;
    logic [AW:0]   count_q;

    assign full_o  = count_q == (AW+1)'(DEPTH);
    assign empty_o = count_q == '0;
    assign head_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
        end
    end

    // Storage carries no reset: a word is only ever read after being written.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= data_i;
    end
endmodule

// File: rtl/switch_ingress_arbiter.sv
// switch_ingress_arbiter: per-port FIFOs feeding a round-robin arbiter with
// registered one-hot request and per-port data outputs.
module switch_ingress_arbiter
    import switch_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_PORTS-1:0] in_valid,
    output logic [NUM_PORTS-1:0] in_ready,
    input  word_t                in_data [NUM_PORTS],
    input  logic                 out_ready,
    output logic [NUM_PORTS-1:0] R,
    output word_t                D [NUM_PORTS]
);
    logic [NUM_PORTS-1:0] full, empty, push, pop;
    word_t                head [NUM_PORTS];
    logic [NUM_PORTS-1:0] r_q;
    word_t                d_q [NUM_PORTS];
    port_idx_t            rr_ptr_q, win;
    logic                 found, load;

    assign in_ready = ~full;
    assign push     = in_valid & in_ready;
    assign load     = (r_q == '0) || out_ready;
    assign pop      = (load && found) ? (NUM_PORTS'(1) << win) : '0;
    assign R        = r_q;
    assign D        = d_q;

    // Scan from the farthest offset down so the nearest non-empty port wins.
    always_comb begin
        found = 1'b0;
        win   = rr_ptr_q;
        for (int o = NUM_PORTS - 1; o >= 0; o--) begin
            if (!empty[port_add(rr_ptr_q, o)]) begin
                found = 1'b1;
                win   = port_add(rr_ptr_q, o);
            end
        end
    end

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
        switch_port_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
            .clk    (clk),
            .rst_n  (rst_n),
            .push_i (push[g]),
            .pop_i  (pop[g]),
            .data_i (in_data[g]),
            .full_o (full[g]),
            .empty_o(empty[g]),
            .head_o (head[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q      <= '0;
            rr_ptr_q <= '0;
            for (int j = 0; j < NUM_PORTS; j++) d_q[j] <= '0;
        end else if (load) begin
            r_q <= pop;
            for (int j = 0; j < NUM_PORTS; j++) d_q[j] <= pop[j] ? head[j] : '0;
            if (found) rr_ptr_q <= port_add(win, 1);
        end
    end
endmodule

// File: tb/tb_switch_ingress_arbiter.sv
// tb_switch_ingress_arbiter: vector table, directed corner sequences and a queue-based random model.
module tb_switch_ingress_arbiter;
    import switch_pkg::*;

    typedef struct {
        logic [3:0] vin;
        logic       ordy;
        logic [3:0] er;
    } vec_t;

    logic                 clk = 1'b0, rst_n = 1'b1, out_ready = 1'b0;
    logic [NUM_PORTS-1:0] in_valid = '0, in_ready, R;
    word_t                in_data [NUM_PORTS];
    word_t                D [NUM_PORTS];
    int                   checks = 0, failures = 0;
    vec_t                 tbl [12];

    word_t                q [NUM_PORTS][$];
    int                   rr, k;
    logic [3:0]           mr, exp_rdy;
    word_t                md [NUM_PORTS];
    word_t                w;

    always #5 clk = ~clk;

    switch_ingress_arbiter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_ready(out_ready),
        .R        (R),
        .D        (D)
    );

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_out(string name, logic [3:0] er, word_t ew);
        chk({name, ".R"}, 32'(R), 32'(er));
        for (int j = 0; j < NUM_PORTS; j++)
            chk($sformatf("%s.D%0d", name, j), D[j], er[j] ? ew : 32'h0);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < NUM_PORTS; i++) in_data[i] = 32'hC0DE_0000 | 32'(i);
        tbl[0]  = '{4'b1111, 1'b1, 4'b0000};
        tbl[1]  = '{4'b0000, 1'b1, 4'b0001};
        tbl[2]  = '{4'b0000, 1'b1, 4'b0010};
        tbl[3]  = '{4'b0000, 1'b1, 4'b0100};
        tbl[4]  = '{4'b0000, 1'b1, 4'b1000};
        tbl[5]  = '{4'b0000, 1'b1, 4'b0000};
        tbl[6]  = '{4'b1001, 1'b1, 4'b0000};
        tbl[7]  = '{4'b1001, 1'b1, 4'b0001};
        tbl[8]  = '{4'b1001, 1'b1, 4'b1000};
        tbl[9]  = '{4'b1001, 1'b1, 4'b0001};
        tbl[10] = '{4'b1001, 1'b1, 4'b1000};
        tbl[11] = '{4'b1001, 1'b1, 4'b0001};

        #1 rst_n = 1'b0;
        #2;
        chk_out("reset", 4'b0000, 32'h0);
        chk("reset.in_ready", 32'(in_ready), 32'hF);
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            in_valid  = tbl[i].vin;
            out_ready = tbl[i].ordy;
            tick();
            w = 32'h0;
            for (int j = 0; j < NUM_PORTS; j++) if (tbl[i].er[j]) w = 32'hC0DE_0000 | 32'(j);
            chk_out($sformatf("tbl%0d", i), tbl[i].er, w);
        end

        in_valid = '0;
        #2 rst_n = 1'b0;
        #1;
        chk_out("midreset", 4'b0000, 32'h0);
        chk("midreset.in_ready", 32'(in_ready), 32'hF);
        @(negedge clk) rst_n = 1'b1;

        in_valid   = 4'b0100;
        in_data[2] = 32'hDEADBEEF;
        out_ready  = 1'b1;
        tick();
        chk_out("single.t", 4'b0000, 32'h0);
        in_valid = '0;
        tick();
        chk_out("single.t1", 4'b0100, 32'hDEADBEEF);
        tick();
        chk_out("single.t2", 4'b0000, 32'h0);

        out_ready  = 1'b0;
        in_valid   = 4'b0010;
        in_data[1] = 32'h1111_0000;
        tick();
        in_valid = '0;
        tick();
        chk_out("hold.first", 4'b0010, 32'h1111_0000);
        for (int n = 1; n <= 5; n++) begin
            in_data[1] = 32'h1111_0000 | 32'(n);
            in_valid   = 4'b0010;
            tick();
            chk_out($sformatf("hold.push%0d", n), 4'b0010, 32'h1111_0000);
            if (n >= 4) chk($sformatf("hold.in_ready%0d", n), 32'(in_ready), 32'hD);
        end
        in_valid  = '0;
        out_ready = 1'b1;
        for (int n = 1; n <= 4; n++) begin
            tick();
            chk_out($sformatf("drain%0d", n), 4'b0010, 32'h1111_0000 | 32'(n));
        end
        tick();
        chk_out("drain.end", 4'b0000, 32'h0);

        out_ready = 1'b0;
        in_data[0] = 32'hAAAA_0000;
        in_data[2] = 32'hBBBB_0000;
        in_valid  = 4'b0101;
        tick();
        tick();
        in_valid = 4'b0001;
        tick();
        in_valid = '0;
        chk_out("partial", 4'b0100, 32'hBBBB_0000);
        #2 rst_n = 1'b0;
        #1;
        chk_out("partial.reset", 4'b0000, 32'h0);
        chk("partial.in_ready", 32'(in_ready), 32'hF);
        @(negedge clk) rst_n = 1'b1;
        out_ready = 1'b1;
        for (int n = 0; n < 10; n++) begin
            tick();
            chk_out($sformatf("stale%0d", n), 4'b0000, 32'h0);
        end

        in_valid = '0;
        #2 rst_n = 1'b0;
        #1 @(negedge clk) rst_n = 1'b1;
        rr = 0;
        mr = '0;
        for (int j = 0; j < NUM_PORTS; j++) md[j] = '0;
        for (int c = 0; c < 400; c++) begin
            in_valid  = 4'($urandom);
            out_ready = $urandom_range(0, 3) != 0;
            for (int i = 0; i < NUM_PORTS; i++) in_data[i] = $urandom;
            for (int i = 0; i < NUM_PORTS; i++) exp_rdy[i] = q[i].size() < FIFO_DEPTH;
            chk($sformatf("rand%0d.in_ready", c), 32'(in_ready), 32'(exp_rdy));
            if (mr == '0 || out_ready) begin
                k = -1;
                for (int o = 0; o < NUM_PORTS; o++)
                    if (k < 0 && q[(rr + o) % NUM_PORTS].size() > 0) k = (rr + o) % NUM_PORTS;
                mr = '0;
                for (int j = 0; j < NUM_PORTS; j++) md[j] = '0;
                if (k >= 0) begin
                    mr[k] = 1'b1;
                    md[k] = q[k].pop_front();
                    rr    = (k + 1) % NUM_PORTS;
                end
            end
            for (int i = 0; i < NUM_PORTS; i++)
                if (in_valid[i] && exp_rdy[i]) q[i].push_back(in_data[i]);
            tick();
            chk($sformatf("rand%0d.R", c), 32'(R), 32'(mr));
            for (int j = 0; j < NUM_PORTS; j++)
                chk($sformatf("rand%0d.D%0d", c, j), D[j], md[j]);
            chk($sformatf("rand%0d.onehot0", c), 32'($onehot0(R)), 32'h1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
